// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-lite FSM state encoding and response codes
package axi_lite_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RSP   = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-lite initiator
// Define AXI_LITE_MASTER_ERRCNT_EN to add the saturating err_count output.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                      rsp_valid,
  output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
`ifdef AXI_LITE_MASTER_ERRCNT_EN
  ,
  output logic [7:0]                err_count
`endif
);

  localparam int STRB_W = C_DATA_WIDTH / 8;

  state_e                    state_q, state_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [C_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [C_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic [C_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                resp_q, resp_d;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid_q && m_axi_awready;
  assign w_hs  = wvalid_q && m_axi_wready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            state_d   = S_WADDR;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RADDR;
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WADDR: begin
        // AW and W complete independently; leave as soon as both are done,
        // counting a handshake that lands in this very cycle.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          state_d = S_RSP;
        end
      end
      S_RADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

`ifdef AXI_LITE_MASTER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == S_RSP) && (resp_q != RESP_OKAY) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign cmd_ready     = (state_q == S_IDLE);
  assign rsp_valid     = (state_q == S_RSP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == S_WRESP);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == S_RDATA);

endmodule
